mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port word-level arbiter that shares the single four-banked main memory between the instruction-cache and data-cache controllers. Each cache controller issues one read or write at a time. The arbiter captures it, waits until the target bank is free, and issues it to memory. It tracks in-flight reads through the memory's fixed latency and returns a one-cycle done pulse, read data and error to the owning port. Different-bank accesses from the two ports may overlap in memory.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- NBANK, 4, memory banks; bank index = addr[2:1]

Ports (X = i for I-cache, d for D-cache). Reset rst is asynchronous, active-high; clock is clk.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- X_rd, X_wr  in  1  request strobes, sampled when X_stall=0
- X_addr  in  ADDR_W  request address
- X_wdata  in  DATA_W  write data
- X_stall  out  1  port busy; request not accepted
- X_done  out  1  one-cycle completion pulse
- X_rdata  out  DATA_W  read data, valid with X_done
- X_err  out  1  error, valid with X_done
- mem_rd, mem_wr  out  1  memory strobes, at most one per cycle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_busy  in  NBANK  per-bank busy
- mem_stall  in  1  memory cannot accept this cycle
- mem_err  in  1  memory error, sampled in the issue cycle

## Operation
- Each port has a FSM with three states:
  - EMPTY -> PENDING on accept (X_rd|X_wr while EMPTY); addr, data and op are registered.
  - PENDING -> INFLIGHT on issue.
  - INFLIGHT -> EMPTY on the edge that raises X_done.
- X_stall = (state != EMPTY).
- A port is eligible when PENDING, mem_stall=0 and mem_busy[bank]=0. At most one eligible port issues per cycle, chosen by the selection policy (see Configuration).
- Issue drives mem_rd or mem_wr, mem_addr and mem_wdata from the port's registers, combinationally, for one cycle.
- Read tracking uses a 2-stage shift register of {valid, port, err}. mem_rdata is captured when the entry reaches stage 2.
- X_rd and X_wr asserted together: the request is accepted, no memory access is made, and X_done=1, X_err=1 one cycle after accept.
- mem_err in the issue cycle is carried with the transaction and reported on X_err.
- Both ports PENDING to the same busy bank: neither issues and both wait.
- Reset at any point clears all port states, the tracking pipe and the round-robin pointer. In-flight memory results are discarded and produce no X_done.
- Reset values: all outputs 0, X_rdata 0.

## Timing
- Request sampled at edge A; PENDING in cycle A+1; earliest issue is cycle A+1.
- Issue in cycle I:
  - Write: X_done in cycle I+1.
  - Read: mem_rdata is valid in cycle I+2 and registered; X_done and X_rdata in cycle I+3.
- X_stall falls in the X_done cycle. A new request can be accepted at the edge ending that cycle.
- Best-case read, request to done: 4 cycles.
- Both ports can receive X_done in the same cycle.
- A blocked port waits indefinitely. No timeout.

## Configuration
- ARB_RR_EN defined: round-robin selection. A 1-bit last-grant pointer is updated on every issue. When both ports are eligible, the port not last granted wins. The pointer resets to "D granted last", so I wins the first tie.
- ARB_RR_EN undefined: fixed priority, D beats I on every tie. There is no pointer register, and I can starve under continuous D traffic.

## Structure
- Package mem_arb_pkg holds:
  - port-id constants PORT_I=0, PORT_D=1
  - port FSM encodings EMPTY/PENDING/INFLIGHT
  - READ_LAT=2
  - the bank-select bit positions
- One sub-module, arb_pick, is natural: a 2-way selector taking the eligible vector and the pointer and returning grant plus next pointer. The ARB_RR_EN choice lives there.

## Test plan
- D read 0x0010, idle memory -> mem_rd in cycle A+1; d_done with d_rdata=mem value in cycle A+4; d_stall high for cycles A+1..A+3.
- I read 0x0002 (bank 1) and D write 0x0004 (bank 2) in the same cycle -> issues on consecutive cycles, tie broken per the compiled policy; both done pulses arrive with the correct latencies.
- Both ports request bank 0 with mem_busy[0]=1 for 3 cycles -> no issue until busy drops. With ARB_RR_EN, grants alternate over 4 repeated rounds; without it, D wins every round.
- i_rd=i_wr=1 -> no mem strobe; i_done=1, i_err=1 next cycle.
- mem_err=1 during a D read issue -> d_done with d_err=1 three cycles later.
- rst asserted in cycle I+1 of an in-flight read -> all outputs 0 immediately; no later d_done; next request is accepted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and types for the two-port memory arbiter.
//   - port identifiers (I-cache / D-cache)
//   - per-port FSM encodings
//   - fixed memory read latency and bank-select bit positions
//   - read-tracking pipe entry type
package mem_arb_pkg;

  localparam logic [0:0] PORT_I = 1'b0;
  localparam logic [0:0] PORT_D = 1'b1;

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_PENDING  = 2'd1;
  localparam logic [1:0] ST_INFLIGHT = 2'd2;

  localparam int READ_LAT = 2;

  // bank index = addr[BANK_MSB:BANK_LSB]
  localparam int BANK_LSB = 1;
  localparam int BANK_MSB = 2;

  typedef struct packed {
    logic valid;
    logic port;
    logic err;
  } trk_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the I-cache port, D-cache port and main-memory
// bus seen by mem_arbiter.
//   slave  : arbiter view (requests/memory responses in, status/strobes out)
//   master : environment view (cache controllers plus memory)
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int NBANK  = 4
) ();
  import mem_arb_pkg::*;

  logic              i_rd, i_wr, i_stall, i_done, i_err;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata, i_rdata;

  logic              d_rd, d_wr, d_stall, d_done, d_err;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;

  logic              mem_rd, mem_wr, mem_stall, mem_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [NBANK-1:0]  mem_busy;

  modport slave (
    input  i_rd, i_wr, i_addr, i_wdata,
    output i_stall, i_done, i_rdata, i_err,
    input  d_rd, d_wr, d_addr, d_wdata,
    output d_stall, d_done, d_rdata, d_err,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_busy, mem_stall, mem_err
  );

  modport master (
    output i_rd, i_wr, i_addr, i_wdata,
    input  i_stall, i_done, i_rdata, i_err,
    output d_rd, d_wr, d_addr, d_wdata,
    input  d_stall, d_done, d_rdata, d_err,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_busy, mem_stall, mem_err
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: 2-way grant selector for mem_arbiter.
//   eligible   in  2  per-port eligibility (bit PORT_I / PORT_D)
//   grant      out 2  one-hot grant (or zero)
//   last_grant in  1  port granted most recently   (ARB_RR_EN only)
//   last_next  out 1  pointer value after this cycle (ARB_RR_EN only)
// Build option: ARB_RR_EN selects round-robin; otherwise D has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  output logic [1:0] grant
`ifdef ARB_RR_EN
  ,
  input  logic       last_grant,
  output logic       last_next
`endif
);

`ifdef ARB_RR_EN
  always_comb begin
    grant     = eligible;
    last_next = last_grant;
    // On a tie the port that did not win last time takes the grant.
    if (&eligible) begin
      grant = (last_grant == PORT_D) ? 2'b01 : 2'b10;
    end
    if (grant[PORT_D]) begin
      last_next = PORT_D;
    end else if (grant[PORT_I]) begin
      last_next = PORT_I;
    end
  end
`else
  always_comb begin
    grant         = '0;
    grant[PORT_D] = eligible[PORT_D];
    grant[PORT_I] = eligible[PORT_I] & ~eligible[PORT_D];
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one four-banked main memory between the I-cache and
// D-cache controllers. Each port holds one request (EMPTY/PENDING/INFLIGHT),
// issues it when its bank is free, and returns a one-cycle done pulse with
// read data and error. Reads are tracked through the fixed memory latency by
// a small {valid, port, err} shift register.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  mem_arbiter_if.slave: i_* / d_* cache ports and mem_* memory bus
// Build option: ARB_RR_EN enables round-robin tie breaking (else D priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int NBANK  = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int BANK_W = $clog2(NBANK);

  logic [1:0]        req_rd, req_wr;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];

  logic [ADDR_W-1:0] addr_q  [2];
  logic [DATA_W-1:0] wdata_q [2];
  logic [DATA_W-1:0] rdata_q [2];
  logic [1:0]        wr_q, stall_q, done_q, err_q;
  logic [1:0]        eligible, grant;

  logic issue, sel, issue_rd;
  trk_t pipe_reg [READ_LAT];

  assign req_rd = {bus.d_rd, bus.i_rd};
  assign req_wr = {bus.d_wr, bus.i_wr};
  assign req_addr[PORT_I]  = bus.i_addr;
  assign req_addr[PORT_D]  = bus.d_addr;
  assign req_wdata[PORT_I] = bus.i_wdata;
  assign req_wdata[PORT_D] = bus.d_wdata;

  // Per-port request FSM
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [1:0]        state_reg;
      logic [ADDR_W-1:0] addr_reg;
      logic [DATA_W-1:0] wdata_reg, rdata_reg;
      logic              wr_reg, done_reg, err_reg;
      logic [BANK_W-1:0] bank;
      logic              rd_ret;

      assign bank   = addr_reg[BANK_LSB +: BANK_W];
      assign rd_ret = pipe_reg[READ_LAT-1].valid &&
                      (pipe_reg[READ_LAT-1].port == 1'(gi));
      assign eligible[gi] = (state_reg == ST_PENDING) && !bus.mem_stall &&
                            !bus.mem_busy[bank];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= ST_EMPTY;
          addr_reg  <= '0;
          wdata_reg <= '0;
          rdata_reg <= '0;
          wr_reg    <= 1'b0;
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
        end else begin
          done_reg <= 1'b0;
          err_reg  <= 1'b0;
          case (state_reg)
            ST_EMPTY: begin
              if (req_rd[gi] && req_wr[gi]) begin
                // Illegal op: answered with an error, never reaches memory.
                done_reg <= 1'b1;
                err_reg  <= 1'b1;
              end else if (req_rd[gi] || req_wr[gi]) begin
                state_reg <= ST_PENDING;
                addr_reg  <= req_addr[gi];
                wdata_reg <= req_wdata[gi];
                wr_reg    <= req_wr[gi];
              end
            end
            ST_PENDING: begin
              if (grant[gi]) begin
                if (wr_reg) begin
                  // Writes complete at the issue edge, so INFLIGHT is skipped.
                  done_reg  <= 1'b1;
                  err_reg   <= bus.mem_err;
                  state_reg <= ST_EMPTY;
                end else begin
                  state_reg <= ST_INFLIGHT;
                end
              end
            end
            ST_INFLIGHT: begin
              if (rd_ret) begin
                done_reg  <= 1'b1;
                err_reg   <= pipe_reg[READ_LAT-1].err;
                rdata_reg <= bus.mem_rdata;
                state_reg <= ST_EMPTY;
              end
            end
            default: state_reg <= ST_EMPTY;
          endcase
        end
      end

      assign addr_q[gi]  = addr_reg;
      assign wdata_q[gi] = wdata_reg;
      assign rdata_q[gi] = rdata_reg;
      assign wr_q[gi]    = wr_reg;
      assign done_q[gi]  = done_reg;
      assign err_q[gi]   = err_reg;
      assign stall_q[gi] = (state_reg != ST_EMPTY);
    end
  endgenerate

  // Grant selection
`ifdef ARB_RR_EN
  logic last_reg, last_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg <= PORT_D;
    end else begin
      last_reg <= last_next;
    end
  end

  arb_pick u_pick (
    .eligible   (eligible),
    .grant      (grant),
    .last_grant (last_reg),
    .last_next  (last_next)
  );
`else
  arb_pick u_pick (
    .eligible (eligible),
    .grant    (grant)
  );
`endif

  // Memory issue: driven combinationally from the granted port's registers
  assign issue    = |grant;
  assign sel      = grant[PORT_D];
  assign issue_rd = issue & ~wr_q[sel];

  assign bus.mem_rd    = issue_rd;
  assign bus.mem_wr    = issue & wr_q[sel];
  assign bus.mem_addr  = issue ? addr_q[sel]  : '0;
  assign bus.mem_wdata = issue ? wdata_q[sel] : '0;

  // Read tracking: the last stage lines up with valid mem_rdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < READ_LAT; k++) begin
        pipe_reg[k] <= '0;
      end
    end else begin
      pipe_reg[0] <= trk_t'{valid: issue_rd, port: sel, err: bus.mem_err & issue_rd};
      for (int k = 1; k < READ_LAT; k++) begin
        pipe_reg[k] <= pipe_reg[k-1];
      end
    end
  end

  assign bus.i_stall = stall_q[PORT_I];
  assign bus.d_stall = stall_q[PORT_D];
  assign bus.i_done  = done_q[PORT_I];
  assign bus.d_done  = done_q[PORT_D];
  assign bus.i_err   = err_q[PORT_I];
  assign bus.d_err   = err_q[PORT_D];
  assign bus.i_rdata = rdata_q[PORT_I];
  assign bus.d_rdata = rdata_q[PORT_D];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16), .NBANK(4)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .NBANK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.i_rd = 0; bus.i_wr = 0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.d_rd = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_busy = '0; bus.mem_stall = 0; bus.mem_err = 0;
    bus.mem_rdata = 16'hDEAD;
  endtask

  logic        prev_d, w_d;
  logic [15:0] i_data, d_data;

  initial begin
    rst = 1'b1;
    idle();
    nxt(); #1;
    $display("txn: reset");
    check("rst_i_stall", bus.i_stall, 0);
    check("rst_d_stall", bus.d_stall, 0);
    check("rst_done",    {bus.i_done, bus.d_done}, 0);
    check("rst_err",     {bus.i_err, bus.d_err}, 0);
    check("rst_rdata",   {bus.i_rdata, bus.d_rdata}, 0);
    check("rst_mem",     {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 0);
    nxt(); rst = 1'b0;

    // D read, idle memory
    nxt(); bus.d_rd = 1; bus.d_addr = 16'h0010; #1;
    $display("txn: D read 0x0010");
    check("t1_stall_A", bus.d_stall, 0);
    nxt(); bus.d_rd = 0; #1;
    check("t1_stall_A1", bus.d_stall, 1);
    check("t1_mem_rd",   bus.mem_rd, 1);
    check("t1_mem_wr",   bus.mem_wr, 0);
    check("t1_mem_addr", bus.mem_addr, 16'h0010);
    nxt(); #1;
    check("t1_stall_A2", bus.d_stall, 1);
    check("t1_rd_once",  bus.mem_rd, 0);
    nxt(); bus.mem_rdata = 16'h1234; #1;
    check("t1_stall_A3", bus.d_stall, 1);
    check("t1_early",    bus.d_done, 0);
    nxt(); bus.mem_rdata = 16'hDEAD; #1;
    check("t1_done",  bus.d_done, 1);
    check("t1_rdata", bus.d_rdata, 16'h1234);
    check("t1_err",   bus.d_err, 0);
    check("t1_stall_A4", bus.d_stall, 0);
    nxt(); #1;
    check("t1_pulse", bus.d_done, 0);

    // I read bank 1 and D write bank 2 together
    nxt();
    bus.i_rd = 1; bus.i_addr = 16'h0002;
    bus.d_wr = 1; bus.d_addr = 16'h0004; bus.d_wdata = 16'hBEEF; #1;
    $display("txn: I read 0x0002 + D write 0x0004 (rr=%0d)", RR);
    nxt(); idle(); #1;
    check("t2_c1_rd",   bus.mem_rd, RR);
    check("t2_c1_wr",   bus.mem_wr, !RR);
    check("t2_c1_addr", bus.mem_addr, RR ? 16'h0002 : 16'h0004);
    nxt(); #1;
    check("t2_c2_rd",   bus.mem_rd, !RR);
    check("t2_c2_wr",   bus.mem_wr, RR);
    check("t2_c2_addr", bus.mem_addr, RR ? 16'h0004 : 16'h0002);
    check("t2_c2_wdata", bus.mem_wdata, RR ? 16'hBEEF : 16'h0000);
    check("t2_c2_d_done", bus.d_done, !RR);
    nxt(); bus.mem_rdata = RR ? 16'h5A5A : 16'hDEAD; #1;
    check("t2_c3_d_done", bus.d_done, RR);
    check("t2_c3_i_done", bus.i_done, 0);
    nxt(); bus.mem_rdata = RR ? 16'hDEAD : 16'h5A5A; #1;
    check("t2_c4_i_done",  bus.i_done, RR);
    check("t2_c4_i_rdata", bus.i_rdata, RR ? 16'h5A5A : 16'h0000);
    nxt(); bus.mem_rdata = 16'hDEAD; #1;
    check("t2_c5_i_done",  bus.i_done, !RR);
    check("t2_c5_i_rdata", bus.i_rdata, 16'h5A5A);
    check("t2_c5_i_err",   bus.i_err, 0);

    // Both ports contend for busy bank 0, four rounds
    prev_d = 1'b0;
    for (int r = 0; r < 4; r++) begin
      w_d = RR ? r[0] : 1'b1;
      nxt(); bus.mem_busy = 4'b0001;
      if (r == 0 || !prev_d) begin
        i_data = 16'h1100 + 16'(r);
        bus.i_wr = 1; bus.i_addr = 16'h0000; bus.i_wdata = i_data;
      end
      if (r == 0 || prev_d) begin
        d_data = 16'h2200 + 16'(r);
        bus.d_wr = 1; bus.d_addr = 16'h0008; bus.d_wdata = d_data;
      end
      #1;
      $display("txn: bank-0 contention round %0d, expect %s", r, w_d ? "D" : "I");
      if (r > 0) begin
        check("rr_prev_i_done", bus.i_done, !prev_d);
        check("rr_prev_d_done", bus.d_done, prev_d);
      end
      for (int k = 0; k < 3; k++) begin
        nxt(); bus.i_wr = 0; bus.d_wr = 0; #1;
        check("rr_blocked", {bus.mem_rd, bus.mem_wr}, 0);
      end
      nxt(); bus.mem_busy = 4'b0000; #1;
      check("rr_issue", bus.mem_wr, 1);
      check("rr_addr",  bus.mem_addr, w_d ? 16'h0008 : 16'h0000);
      check("rr_wdata", bus.mem_wdata, w_d ? d_data : i_data);
      prev_d = w_d;
    end
    nxt(); #1;
    check("rr_last_d_done", bus.d_done, prev_d);
    check("rr_last_i_done", bus.i_done, !prev_d);
    check("rr_loser_issue", bus.mem_wr, 1);
    check("rr_loser_addr",  bus.mem_addr, prev_d ? 16'h0000 : 16'h0008);
    nxt(); #1;
    check("rr_loser_i_done", bus.i_done, prev_d);
    check("rr_loser_d_done", bus.d_done, !prev_d);

    // Illegal read+write on I
    nxt(); bus.i_rd = 1; bus.i_wr = 1; bus.i_addr = 16'h0020; #1;
    $display("txn: I read+write illegal");
    nxt(); idle(); #1;
    check("t4_no_strobe", {bus.mem_rd, bus.mem_wr}, 0);
    check("t4_done", bus.i_done, 1);
    check("t4_err",  bus.i_err, 1);
    nxt(); #1;
    check("t4_pulse", {bus.i_done, bus.i_err}, 0);

    // Memory error on a D read issue
    nxt(); bus.d_rd = 1; bus.d_addr = 16'h0006; #1;
    $display("txn: D read 0x0006 with mem_err");
    nxt(); bus.d_rd = 0; bus.mem_err = 1; #1;
    check("t5_issue", bus.mem_rd, 1);
    nxt(); bus.mem_err = 0; #1;
    nxt(); bus.mem_rdata = 16'h7777; #1;
    check("t5_early", bus.d_done, 0);
    nxt(); bus.mem_rdata = 16'hDEAD; #1;
    check("t5_done",  bus.d_done, 1);
    check("t5_err",   bus.d_err, 1);
    check("t5_rdata", bus.d_rdata, 16'h7777);

    // Reset during an in-flight read
    nxt(); bus.d_rd = 1; bus.d_addr = 16'h0010; #1;
    $display("txn: D read 0x0010 aborted by reset");
    nxt(); bus.d_rd = 0; #1;
    check("t6_issue", bus.mem_rd, 1);
    nxt(); rst = 1'b1; #1;
    check("t6_rst_stall", bus.d_stall, 0);
    check("t6_rst_mem",   {bus.mem_rd, bus.mem_wr}, 0);
    check("t6_rst_rdata", bus.d_rdata, 0);
    nxt(); rst = 1'b0; bus.mem_rdata = 16'h4321; #1;
    check("t6_no_done0", bus.d_done, 0);
    nxt(); bus.mem_rdata = 16'hDEAD; #1;
    check("t6_no_done1", bus.d_done, 0);
    nxt(); #1;
    check("t6_no_done2", bus.d_done, 0);
    nxt(); bus.d_rd = 1; bus.d_addr = 16'h0012; #1;
    $display("txn: D read 0x0012 after reset");
    nxt(); bus.d_rd = 0; #1;
    check("t6_new_issue", bus.mem_rd, 1);
    check("t6_new_addr",  bus.mem_addr, 16'h0012);
    nxt(); #1;
    nxt(); bus.mem_rdata = 16'h0BAD; #1;
    nxt(); bus.mem_rdata = 16'hDEAD; #1;
    check("t6_new_done",  bus.d_done, 1);
    check("t6_new_rdata", bus.d_rdata, 16'h0BAD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
